// File: rtl/tiger_leap_pkg.sv
// tiger_leap_pkg: MIPS call/return decode constants and profiler state encoding
package tiger_leap_pkg;
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;
    localparam logic [4:0] REG_RA     = 5'd31;
    typedef enum logic [2:0] {IDLE, RUN, CALL_DS, CALL_TGT, RET_DS, DONE} state_t;
endpackage

// File: rtl/leap_call_stack.sv
// leap_call_stack: LIFO of function IDs with sticky overflow/underflow flags
module leap_call_stack #(
    parameter int W     = 4,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         ovf,
    output logic         unf
);
    localparam int SP_W = $clog2(DEPTH + 1);
    localparam int AW   = $clog2(DEPTH);
    logic [W-1:0]    mem [DEPTH];
    logic [SP_W-1:0] sp;
    logic            empty, full;
    assign empty = sp == '0;
    assign full  = sp == SP_W'(DEPTH);
    // An empty pop yields ID 0 so the caller falls back to "unmatched"
    assign top   = empty ? '0 : mem[AW'(sp - SP_W'(1))];
    always_ff @(posedge clk)
        if (push && !full) mem[AW'(sp)] <= din;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sp  <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (push) begin
            ovf <= ovf | full;
            sp  <= full ? sp : sp + SP_W'(1);
        end else if (pop) begin
            unf <= unf | empty;
            sp  <= empty ? sp : sp - SP_W'(1);
        end
    end
endmodule

// File: rtl/leap_profile_counter.sv
// leap_profile_counter: per-function cycle profiler on the retired-instruction trace; LEAP_STALL_SPLIT_EN adds per-function stall-cycle counters
module leap_profile_counter
    import tiger_leap_pkg::*;
#(
    parameter int          N_FUNC      = 16,
    parameter int          FUNC_W      = 4,
    parameter int          STACK_DEPTH = 16,
    parameter int          CNT_W       = 32,
    parameter logic [31:0] START_PC    = 32'h0080_0000,
    parameter logic [31:0] FINISH_PC   = 32'h0080_0008
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [31:0]       pc,
    input  logic              trace_valid,
    input  logic [31:0]       trace_pc,
    input  logic [31:0]       trace_ins,
    input  logic              iCacheStall,
    input  logic              dCacheStall,
    input  logic              cfg_we,
    input  logic [FUNC_W-1:0] cfg_idx,
    input  logic [31:0]       cfg_addr,
    input  logic [FUNC_W-1:0] rd_idx,
    output logic [CNT_W-1:0]  rd_data,
    output logic              active,
    output logic              done,
    output logic              stk_ovf,
    output logic              stk_unf
`ifdef LEAP_STALL_SPLIT_EN
    ,
    output logic [CNT_W-1:0]  rd_stall_data
`endif
);
    state_t            state, state_nx;
    logic [31:0]       tbl [N_FUNC];
    logic [CNT_W-1:0]  cnt [N_FUNC];
    logic [FUNC_W-1:0] cur_id, stk_top;
    logic              is_call, is_ret, fin, push, pop, count;
    assign is_call = trace_ins[31:26] == OP_JAL ||
                     (trace_ins[31:26] == OP_SPECIAL && trace_ins[5:0] == FN_JALR);
    assign is_ret  = trace_ins[31:26] == OP_SPECIAL && trace_ins[5:0] == FN_JR &&
                     trace_ins[25:21] == REG_RA;
    assign fin     = pc == FINISH_PC;
    function automatic logic [FUNC_W-1:0] lookup(input logic [31:0] a);
        lookup = '0;
        for (int i = N_FUNC - 1; i > 0; i--)
            if (tbl[i] == a) lookup = FUNC_W'(i);
    endfunction
    always_ff @(posedge clk)
        state <= !resetn ? IDLE : state_nx;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:           state_nx = pc == START_PC ? RUN : IDLE;
            RUN:            state_nx = !trace_valid ? RUN : is_call ? CALL_DS : is_ret ? RET_DS : RUN;
            CALL_DS:        state_nx = trace_valid ? CALL_TGT : CALL_DS;
            CALL_TGT,
            RET_DS:         state_nx = trace_valid ? RUN : state;
            default:        state_nx = state;
        endcase
        if (state != IDLE && fin) state_nx = DONE;
    end
    always_comb begin
        active = state inside {RUN, CALL_DS, CALL_TGT, RET_DS};
        done   = state == DONE;
        push   = state == CALL_TGT && trace_valid && !fin;
        pop    = state == RET_DS && trace_valid && !fin;
        count  = active && !fin;
    end
    // The address table survives reset so it can be loaded once per bitstream
    always_ff @(posedge clk)
        if (cfg_we && cfg_idx != '0) tbl[cfg_idx] <= cfg_addr;
    always_ff @(posedge clk)
        cur_id <= !resetn ? '0 :
                  (state == IDLE && state_nx == RUN) ? lookup(START_PC) :
                  push ? lookup(trace_pc) :
                  pop ? stk_top : cur_id;
    leap_call_stack #(.W(FUNC_W), .DEPTH(STACK_DEPTH)) u_stack (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .din    (cur_id),
        .top    (stk_top),
        .ovf    (stk_ovf),
        .unf    (stk_unf)
    );
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < N_FUNC; i++) cnt[i] <= '0;
            rd_data <= '0;
        end else begin
            if (count && cnt[cur_id] != '1) cnt[cur_id] <= cnt[cur_id] + CNT_W'(1);
            rd_data <= cnt[rd_idx];
        end
    end
`ifdef LEAP_STALL_SPLIT_EN
    logic [CNT_W-1:0] stall_cnt [N_FUNC];
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < N_FUNC; i++) stall_cnt[i] <= '0;
            rd_stall_data <= '0;
        end else begin
            if (count && (iCacheStall || dCacheStall) && stall_cnt[cur_id] != '1)
                stall_cnt[cur_id] <= stall_cnt[cur_id] + CNT_W'(1);
            rd_stall_data <= stall_cnt[rd_idx];
        end
    end
`else
    logic unused_stall;
    assign unused_stall = iCacheStall | dCacheStall;
`endif
endmodule

// File: tb/tb_leap_profile_counter.sv
// tb_leap_profile_counter: directed scenarios with a queued scoreboard checking counters and flags
module tb_leap_profile_counter;
    localparam logic [31:0] START  = 32'h0080_0000;
    localparam logic [31:0] FINISH = 32'h0080_0008;
    localparam logic [31:0] F2     = 32'h0080_0100;
    localparam logic [31:0] F3     = 32'h00A0_0300;
    localparam logic [31:0] UNMAP  = 32'h0080_9000;
    localparam logic [31:0] JAL_F2 = 32'h0C20_0040;
    localparam logic [31:0] JAL_F3 = 32'h0C28_00C0;
    localparam logic [31:0] JALR   = 32'h0320_F809;
    localparam logic [31:0] JR_RA  = 32'h03E0_0008;
    localparam logic [31:0] NOP    = 32'h0000_0000;

    logic        clk = 0, resetn = 0, trace_valid = 0, iCacheStall = 0, dCacheStall = 0, cfg_we = 0;
    logic [31:0] pc = 0, trace_pc = 0, trace_ins = 0, cfg_addr = 0;
    logic [3:0]  cfg_idx = 0, rd_idx = 0;
    logic [31:0] rd_data;
    logic        active, done, stk_ovf, stk_unf;
    logic        req = 0, req_q = 0;
    int          n_vec = 0, n_err = 0;
`ifdef LEAP_STALL_SPLIT_EN
    logic [31:0] rd_stall_data;
`endif

    leap_profile_counter dut (
        .clk(clk), .resetn(resetn), .pc(pc), .trace_valid(trace_valid),
        .trace_pc(trace_pc), .trace_ins(trace_ins), .iCacheStall(iCacheStall),
        .dCacheStall(dCacheStall), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .rd_idx(rd_idx), .rd_data(rd_data), .active(active),
        .done(done), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
`ifdef LEAP_STALL_SPLIT_EN
        , .rd_stall_data(rd_stall_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          use_rd;
        logic [31:0] exp_rd;
        logic [3:0]  exp_fl;
        bit          use_st;
        logic [31:0] exp_st;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic idle(input int n);
        repeat (n) tick();
    endtask
    task automatic pulse_pc(input logic [31:0] a);
        pc = a;
        tick();
        pc = 32'h0;
    endtask
    task automatic do_reset();
        resetn = 0;
        idle(2);
        resetn = 1;
    endtask
    task automatic retire(input logic [31:0] a, input logic [31:0] ins);
        trace_valid = 1;
        trace_pc = a;
        trace_ins = ins;
        tick();
        trace_valid = 0;
        trace_ins = NOP;
    endtask
    task automatic call(input logic [31:0] ins, input logic [31:0] tgt);
        retire(32'h0080_0040, ins);
        retire(32'h0080_0044, NOP);
        retire(tgt, NOP);
    endtask
    task automatic ret();
        retire(32'h0080_0080, JR_RA);
        retire(32'h0080_0084, NOP);
    endtask
    // flags are {active, done, stk_ovf, stk_unf}
    task automatic chk(input string n, input logic [3:0] idx, input bit use_rd, input logic [31:0] erd,
                       input logic [3:0] efl, input bit use_st, input logic [31:0] est);
        exp_t x;
        x.name = n; x.use_rd = use_rd; x.exp_rd = erd; x.exp_fl = efl; x.use_st = use_st; x.exp_st = est;
        sb.push_back(x);
        rd_idx = idx;
        req = 1;
        tick();
        req = 0;
    endtask

    always @(posedge clk) req_q <= req;

    always @(negedge clk) if (req_q) begin
        if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL sb_empty: response with no queued expectation");
        end else begin
            e = sb.pop_front();
            n_vec++;
            if ({active, done, stk_ovf, stk_unf} !== e.exp_fl) begin
                n_err++;
                $display("FAIL %s flags: got %b want %b", e.name, {active, done, stk_ovf, stk_unf}, e.exp_fl);
            end
            if (e.use_rd) begin
                n_vec++;
                if (rd_data !== e.exp_rd) begin
                    n_err++;
                    $display("FAIL %s rd_data: got %0d want %0d", e.name, rd_data, e.exp_rd);
                end
            end
`ifdef LEAP_STALL_SPLIT_EN
            if (e.use_st) begin
                n_vec++;
                if (rd_stall_data !== e.exp_st) begin
                    n_err++;
                    $display("FAIL %s rd_stall_data: got %0d want %0d", e.name, rd_stall_data, e.exp_st);
                end
            end
`endif
        end
    end

    initial begin
        do_reset();
        cfg_we = 1;
        cfg_idx = 4'd1; cfg_addr = START; tick();
        cfg_idx = 4'd2; cfg_addr = F2;    tick();
        for (int i = 3; i < 16; i++) begin
            cfg_idx = 4'(i);
            cfg_addr = 32'h00A0_0000 + 32'(i) * 32'h100;
            tick();
        end
        cfg_idx = 4'd0; cfg_addr = UNMAP; tick();
        cfg_we = 0;
        chk("reset_c1", 4'd1, 1, 0, 4'b0000, 0, 0);
        chk("reset_c0", 4'd0, 1, 0, 4'b0000, 0, 0);

        pulse_pc(START);
        idle(100);
        pulse_pc(FINISH);
        chk("idle_c1", 4'd1, 1, 100, 4'b0100, 0, 0);
        chk("idle_c0", 4'd0, 1, 0, 4'b0100, 0, 0);

        do_reset();
        pulse_pc(START);
        idle(10);
        call(JAL_F2, F2);
        dCacheStall = 1;
        idle(20);
        dCacheStall = 0;
        idle(30);
        ret();
        idle(5);
        pulse_pc(FINISH);
        chk("jal_c1", 4'd1, 1, 18, 4'b0100, 0, 0);
        chk("jal_c2", 4'd2, 1, 52, 4'b0100, 1, 20);
        chk("jal_c0", 4'd0, 1, 0, 4'b0100, 1, 0);

        do_reset();
        pulse_pc(START);
        idle(4);
        call(JALR, UNMAP);
        idle(9);
        ret();
        idle(3);
        pulse_pc(FINISH);
        chk("jalr_c0", 4'd0, 1, 11, 4'b0100, 0, 0);
        chk("jalr_c1", 4'd1, 1, 10, 4'b0100, 0, 0);

        do_reset();
        pulse_pc(START);
        repeat (16) call(JAL_F3, F3);
        chk("ovf_16", 4'd0, 0, 0, 4'b1000, 0, 0);
        call(JAL_F3, F3);
        chk("ovf_17", 4'd0, 0, 0, 4'b1010, 0, 0);
        pulse_pc(FINISH);
        chk("ovf_c3", 4'd3, 1, 50, 4'b0110, 0, 0);
        chk("ovf_c1", 4'd1, 1, 3, 4'b0110, 0, 0);

        do_reset();
        pulse_pc(START);
        ret();
        idle(5);
        pulse_pc(FINISH);
        chk("unf_c0", 4'd0, 1, 5, 4'b0101, 0, 0);
        chk("unf_c1", 4'd1, 1, 2, 4'b0101, 0, 0);

        do_reset();
        pulse_pc(START);
        ret();
        idle(2);
        retire(32'h0080_0040, JAL_F2);
        retire(32'h0080_0044, NOP);
        resetn = 0;
        tick();
        resetn = 1;
        chk("midrst_c1", 4'd1, 1, 0, 4'b0000, 0, 0);
        chk("midrst_c0", 4'd0, 1, 0, 4'b0000, 0, 0);
        pc = FINISH;
        idle(3);
        pc = 32'h0;
        chk("idle_fin", 4'd1, 1, 0, 4'b0000, 0, 0);

        idle(3);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
